phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_seq_pkg.sv | 22 ++
 rtl/ms_tick_gen.sv | 38 +++
 rtl/phase_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_phase_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_seq_pkg.sv
// Shared definitions for the LED phase sequencer.
// Holds the FSM state encoding, the default ms prescale, the blink half-period
// and a helper that derives cycles-per-ms from a clock frequency.
package phase_seq_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_CLK_HZ = 10_000_000;
  localparam int unsigned MS_CYCLES      = DEFAULT_CLK_HZ / 1000;
  localparam int unsigned BLINK_MS       = 250;

  // Clock cycles per millisecond for a given clock frequency
  function automatic int unsigned ms_cycles(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : restart the count at zero on the next edge (wins over freeze)
//   freeze     : hold the count and suppress the tick
//   tick_c     : one-cycle pulse in the last cycle of each ms (combinational)
module ms_tick_gen
  import phase_seq_pkg::*;
#(
  parameter int unsigned CYCLES_PER_MS = MS_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic freeze,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_MS - 1);

  logic [CNT_W-1:0] cnt_q;

  // Tick depends only on state, never on clear, to keep the parent loop-free
  assign tick_c = !freeze && (cnt_q == CNT_LAST);

  // Prescale counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Table-driven LED phase sequencer.
// Steps through NUM_PHASES table entries, each lighting a mask (optionally
// blinking at 250 ms) for a programmable number of milliseconds.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   enable            : run while high; low returns to idle with LEDs off
//   hold              : freeze timing and LED state while high
//   skip              : one-cycle pulse ending the current phase
//   cfg_we/addr/mask/dur/blink : table write port, usable in any state
//   led               : registered LED drive
//   phase             : current phase index
//   phase_done        : one-cycle pulse on each phase advance
//   busy              : sequencer not idle
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = 3,
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned CLK_HZ     = 10_000_000,
  parameter int unsigned DUR_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          hold,
  input  logic                          skip,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_PHASES)-1:0] cfg_addr,
  input  logic [NUM_LEDS-1:0]           cfg_mask,
  input  logic [DUR_W-1:0]              cfg_dur,
  input  logic                          cfg_blink,
  output logic [NUM_LEDS-1:0]           led,
  output logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic                          phase_done,
  output logic                          busy
);

  localparam int unsigned PH_W   = $clog2(NUM_PHASES);
  localparam int unsigned BC_W   = $clog2(BLINK_MS);
  localparam int unsigned MS_CYC = ms_cycles(CLK_HZ);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(NUM_PHASES - 1);
  localparam logic [BC_W-1:0]  BLINK_LAST = BC_W'(BLINK_MS - 1);
  localparam logic [DUR_W-1:0] DUR_RESET  = DUR_W'(1000);

  // Sequence table
  logic [NUM_LEDS-1:0] tbl_mask  [NUM_PHASES];
  logic [DUR_W-1:0]    tbl_dur   [NUM_PHASES];
  logic                tbl_blink [NUM_PHASES];

  // Control and shadow registers
  state_e              state_q, state_n;
  logic [PH_W-1:0]     phase_q, phase_n;
  logic [NUM_LEDS-1:0] led_q, led_n;
  logic                done_q, done_n;
  logic                busy_q, busy_n;
  logic [DUR_W-1:0]    ms_cnt_q, ms_cnt_n;
  logic [BC_W-1:0]     blink_cnt_q, blink_cnt_n;
  logic                blink_on_q, blink_on_n;
  logic [NUM_LEDS-1:0] sh_mask_q, sh_mask_n;
  logic [DUR_W-1:0]    sh_last_q, sh_last_n;
  logic                sh_blink_q, sh_blink_n;

  // Decode helpers
  logic                tick_c;
  logic                tick_clear_c;
  logic                expire_c;
  logic                advance_c;
  logic                start_c;
  logic [PH_W-1:0]     nxt_phase_c;
  logic [DUR_W-1:0]    dur_sel_c;

  ms_tick_gen #(
    .CYCLES_PER_MS (MS_CYC)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tick_clear_c),
    .freeze (state_q == ST_PAUSE),
    .tick_c (tick_c)
  );

  // Phase-entry and advance decode; enable outranks skip and expiry
  always_comb begin
    expire_c     = tick_c && (ms_cnt_q == sh_last_q);
    advance_c    = (state_q == ST_RUN) && enable && (skip || expire_c);
    start_c      = (state_q == ST_IDLE) && enable;
    nxt_phase_c  = '0;
    if (!start_c && (phase_q != PH_LAST)) begin
      nxt_phase_c = phase_q + PH_W'(1);
    end
    dur_sel_c    = tbl_dur[nxt_phase_c];
    tick_clear_c = (state_q == ST_IDLE) || advance_c;
  end

  // Next state and registered-output values
  always_comb begin
    state_n     = state_q;
    phase_n     = phase_q;
    led_n       = led_q;
    done_n      = 1'b0;
    ms_cnt_n    = ms_cnt_q;
    blink_cnt_n = blink_cnt_q;
    blink_on_n  = blink_on_q;
    sh_mask_n   = sh_mask_q;
    sh_last_n   = sh_last_q;
    sh_blink_n  = sh_blink_q;

    unique case (state_q)
      ST_IDLE:  if (enable) state_n = ST_RUN;
      ST_RUN:   if (!enable) state_n = ST_IDLE;
                else if (hold) state_n = ST_PAUSE;
      ST_PAUSE: if (!enable) state_n = ST_IDLE;
                else if (!hold) state_n = ST_RUN;
      default:  state_n = ST_IDLE;
    endcase

    if (state_n == ST_IDLE) begin
      phase_n     = '0;
      led_n       = '0;
      ms_cnt_n    = '0;
      blink_cnt_n = '0;
      blink_on_n  = 1'b0;
    end else if (start_c || advance_c) begin
      // Phase entry: snapshot the table so later writes wait for re-entry
      phase_n     = nxt_phase_c;
      sh_mask_n   = tbl_mask[nxt_phase_c];
      sh_blink_n  = tbl_blink[nxt_phase_c];
      sh_last_n   = (dur_sel_c == '0) ? '0 : dur_sel_c - DUR_W'(1);
      ms_cnt_n    = '0;
      blink_cnt_n = '0;
      blink_on_n  = 1'b1;
      led_n       = tbl_mask[nxt_phase_c];
      done_n      = advance_c;
    end else if ((state_q == ST_RUN) && tick_c) begin
      ms_cnt_n = ms_cnt_q + DUR_W'(1);
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_n = '0;
        blink_on_n  = !blink_on_q;
      end else begin
        blink_cnt_n = blink_cnt_q + BC_W'(1);
      end
      led_n = (sh_blink_q && !blink_on_n) ? '0 : sh_mask_q;
    end

    busy_n = (state_n != ST_IDLE);
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      led_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ms_cnt_q    <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      sh_mask_q   <= '0;
      sh_last_q   <= '0;
      sh_blink_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      phase_q     <= phase_n;
      led_q       <= led_n;
      done_q      <= done_n;
      busy_q      <= busy_n;
      ms_cnt_q    <= ms_cnt_n;
      blink_cnt_q <= blink_cnt_n;
      blink_on_q  <= blink_on_n;
      sh_mask_q   <= sh_mask_n;
      sh_last_q   <= sh_last_n;
      sh_blink_q  <= sh_blink_n;
    end
  end

  // Table storage; reset pattern walks a single lit LED across the entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        tbl_mask[i]  <= NUM_LEDS'(1 << (i % NUM_LEDS));
        tbl_dur[i]   <= DUR_RESET;
        tbl_blink[i] <= 1'b0;
      end
    end else if (cfg_we) begin
      tbl_mask[cfg_addr]  <= cfg_mask;
      tbl_dur[cfg_addr]   <= cfg_dur;
      tbl_blink[cfg_addr] <= cfg_blink;
    end
  end

  assign led        = led_q;
  assign phase      = phase_q;
  assign phase_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer at 10 clock cycles per ms.
// Each expected phase advance (new phase, new LED value, edge number) is queued
// when the stimulus that causes it is applied; a monitor pops and compares it
// whenever phase_done pulses.
module tb_phase_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       hold;
  logic       skip;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [2:0] cfg_mask;
  logic [15:0] cfg_dur;
  logic       cfg_blink;
  logic [2:0] led;
  logic [1:0] phase;
  logic       phase_done;
  logic       busy;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  typedef struct {
    int         ph;
    logic [2:0] led;
    longint     cyc;
  } exp_t;

  exp_t exp_q[$];

  phase_sequencer #(
    .NUM_LEDS   (3),
    .NUM_PHASES (4),
    .CLK_HZ     (10_000),
    .DUR_W      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .hold       (hold),
    .skip       (skip),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_mask   (cfg_mask),
    .cfg_dur    (cfg_dur),
    .cfg_blink  (cfg_blink),
    .led        (led),
    .phase      (phase),
    .phase_done (phase_done),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: value seen at a negedge is the number of the preceding posedge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ph, input logic [2:0] l, input longint c);
    exp_t e;
    e.ph  = ph;
    e.led = l;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input longint c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [2:0] m, input logic [15:0] d,
                           input logic b);
    cfg_addr  = a;
    cfg_mask  = m;
    cfg_dur   = d;
    cfg_blink = b;
    cfg_we    = 1'b1;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // Pulse skip so that it is sampled by exactly one posedge
  task automatic pulse_skip();
    skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
  endtask

  // Scoreboard: every phase_done must match the oldest queued advance
  always @(negedge clk) begin
    if (phase_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_phase_done", 64'(phase_done), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_phase", 64'(phase), 64'(e.ph));
        check("done_led",   64'(led),   64'(e.led));
        check("done_cycle", 64'(cyc),   64'(e.cyc));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint t, t0, t1, t2, t3, t4, t5, t6, t7, t8, t9;

    rst_n = 1'b0; enable = 1'b0; hold = 1'b0; skip = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_dur = '0; cfg_blink = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led",   64'(led),        64'(0));
    check("rst_phase", 64'(phase),      64'(0));
    check("rst_done",  64'(phase_done), 64'(0));
    check("rst_busy",  64'(busy),       64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));

    // Default table: one-hot walk, 1000 ms per phase, wrap 3 -> 0
    enable = 1'b1;
    t = cyc + 1;
    push(1, 3'b010, t + 10000);
    push(2, 3'b100, t + 20000);
    push(3, 3'b001, t + 30000);
    push(0, 3'b001, t + 40000);
    @(negedge clk);
    check("start_led",   64'(led),   64'(3'b001));
    check("start_phase", 64'(phase), 64'(0));
    check("start_busy",  64'(busy),  64'(1));
    wait_cyc(t + 9999);
    check("p0_last_cycle", 64'(phase), 64'(0));
    wait_cyc(t + 25000);
    check("p2_mid_phase", 64'(phase), 64'(2));
    check("p2_mid_led",   64'(led),   64'(3'b100));
    wait_cyc(t + 35000);
    check("p3_mid_led",   64'(led),   64'(3'b001));
    wait_cyc(t + 40000);
    check("wrap_phase",   64'(phase), 64'(0));
    t0 = t + 40000;

    // Skip 500 cycles into phase 0; phase 1 then runs its full 1000 ms
    wait_cyc(t0 + 499);
    t1 = t0 + 500;
    push(1, 3'b010, t1);
    push(2, 3'b111, t1 + 10000);
    pulse_skip();
    check("skip_phase", 64'(phase), 64'(1));

    // Table writes while in phase 1 only take effect on the next entry
    cfg_write(2'd1, 3'b010, 16'd0, 1'b0);
    cfg_write(2'd2, 3'b111, 16'd1000, 1'b1);
    wait_cyc(t1 + 9999);
    check("shadow_dur_kept", 64'(phase), 64'(1));

    // Blink phase: lit on entry, toggling every 2500 cycles
    t2 = t1 + 10000;
    t3 = t2 + 10000;
    wait_cyc(t2);
    check("blink_entry", 64'(led), 64'(3'b111));
    wait_cyc(t2 + 2499);
    check("blink_2499", 64'(led), 64'(3'b111));
    wait_cyc(t2 + 2500);
    check("blink_2500", 64'(led), 64'(3'b000));
    wait_cyc(t2 + 4999);
    check("blink_4999", 64'(led), 64'(3'b000));
    wait_cyc(t2 + 5000);
    check("blink_5000", 64'(led), 64'(3'b111));
    wait_cyc(t2 + 7500);
    check("blink_7500", 64'(led), 64'(3'b000));
    push(3, 3'b001, t3);

    // Hold 3000 cycles in phase 3: duration stretches by exactly 3000
    t4 = t3 + 13000;
    push(0, 3'b001, t4);
    wait_cyc(t3 + 999);
    hold = 1'b1;
    wait_cyc(t3 + 2500);
    check("hold_led",   64'(led),   64'(3'b001));
    check("hold_phase", 64'(phase), 64'(3));
    check("hold_busy",  64'(busy),  64'(1));
    wait_cyc(t3 + 3999);
    hold = 1'b0;

    // Duration 0 behaves as 1 ms
    wait_cyc(t4 + 9);
    t5 = t4 + 10;
    t6 = t5 + 10;
    push(1, 3'b010, t5);
    push(2, 3'b111, t6);
    pulse_skip();
    wait_cyc(t6);
    check("dur0_next_phase", 64'(phase), 64'(2));

    // Walk round to phase 1 and skip exactly on its natural expiry
    wait_cyc(t6 + 19);
    t7 = t6 + 20;
    push(3, 3'b001, t7);
    pulse_skip();
    wait_cyc(t7 + 4);
    t8 = t7 + 5;
    push(0, 3'b001, t8);
    pulse_skip();
    wait_cyc(t8 + 4);
    t9 = t8 + 5;
    push(1, 3'b010, t9);
    pulse_skip();
    wait_cyc(t9 + 9);
    push(2, 3'b111, t9 + 10);
    pulse_skip();
    repeat (3) @(negedge clk);
    check("coincide_single_adv", 64'(phase), 64'(2));

    // Skip ignored while paused
    hold = 1'b1;
    @(negedge clk);
    pulse_skip();
    hold = 1'b0;
    repeat (2) @(negedge clk);
    check("pause_skip_ignored", 64'(phase), 64'(2));

    // Disable mid-phase 2
    enable = 1'b0;
    @(negedge clk);
    check("disable_led",   64'(led),   64'(0));
    check("disable_phase", 64'(phase), 64'(0));
    check("disable_busy",  64'(busy),  64'(0));
    pulse_skip();
    check("idle_skip_busy", 64'(busy), 64'(0));

    // Re-enable restarts at phase 0
    enable = 1'b1;
    @(negedge clk);
    check("reenable_phase", 64'(phase), 64'(0));
    check("reenable_led",   64'(led),   64'(3'b001));
    check("reenable_busy",  64'(busy),  64'(1));
    push(1, 3'b010, cyc + 1);
    pulse_skip();
    check("pre_reset_phase", 64'(phase), 64'(1));

    // Asynchronous reset mid-sequence
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led",   64'(led),   64'(0));
    check("async_rst_phase", 64'(phase), 64'(0));
    check("async_rst_busy",  64'(busy),  64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_phase", 64'(phase), 64'(0));
    check("post_rst_led",   64'(led),   64'(3'b001));

    // Table back to defaults: entry 1 is 1000 ms, entry 2 is steady 100
    repeat (20) @(negedge clk);
    push(1, 3'b010, cyc + 1);
    pulse_skip();
    repeat (20) @(negedge clk);
    push(2, 3'b100, cyc + 1);
    pulse_skip();
    check("tbl_reset_mask", 64'(led), 64'(3'b100));
    wait_cyc(cyc + 2600);
    check("tbl_reset_noblink", 64'(led), 64'(3'b100));

    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("final_busy", 64'(busy), 64'(0));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
